// File: rtl/mips_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : mips_muldiv
//  Purpose  : Multi-cycle secondary ALU owning HI/LO. Executes MULT, MULTU,
//             DIV, DIVU (radix-2, one bit per cycle) plus MTHI/MTLO/MFHI/MFLO.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_muldiv #(
  parameter int CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_stall,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int CW = $clog2(CYCLES + 1);

  localparam logic [2:0] OP_MFHI = 3'b000;
  localparam logic [2:0] OP_MTHI = 3'b001;
  localparam logic [2:0] OP_MFLO = 3'b010;
  localparam logic [2:0] OP_MTLO = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Multiply: {partial product high, remaining multiplier bits}
  // Divide:   {partial remainder, dividend bits / quotient bits}
  logic [63:0]   acc_q, acc_d;
  // Multiplicand (multiply) or divisor (divide) magnitude
  logic [31:0]   opnd_q, opnd_d;
  logic          is_div_q, is_div_d;
  logic          neg_lo_q, neg_lo_d;   // negate product / quotient
  logic          neg_hi_q, neg_hi_d;   // negate remainder (divide only)
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  // Operand magnitudes and sign bookkeeping for the op being accepted
  logic        w_signed;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;

  // Single-iteration datapath results
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_trial;
  logic [32:0] w_div_diff;
  logic        w_div_ge;
  logic [63:0] w_div_next;
  logic [63:0] w_prod_fix;

  // Operand conditioning and one shift-add / shift-subtract step
  always_comb begin
    w_signed    = ~i_op[0];
    w_a_neg     = w_signed & i_a[31];
    w_b_neg     = w_signed & i_b[31];
    w_a_mag     = w_a_neg ? (32'd0 - i_a) : i_a;
    w_b_mag     = w_b_neg ? (32'd0 - i_b) : i_b;

    w_mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    w_mul_next  = {w_mul_sum, acc_q[31:1]};

    // Remainder shifted left with the next dividend bit; the remainder is
    // always below the divisor so 33 bits cannot overflow.
    w_div_trial = acc_q[63:31];
    w_div_diff  = w_div_trial - {1'b0, opnd_q};
    w_div_ge    = ~w_div_diff[32];
    w_div_next  = w_div_ge ? {w_div_diff[31:0], acc_q[30:0], 1'b1}
                           : {acc_q[62:0], 1'b0};

    w_prod_fix  = neg_lo_q ? (64'd0 - acc_q) : acc_q;
  end

  // Next-state, counter, datapath and HI/LO update logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          if (i_op[2]) begin
            is_div_d = i_op[1];
            cnt_d    = CW'(CYCLES);
            state_d  = ST_CALC;
            neg_hi_d = i_op[1] & w_a_neg;
            neg_lo_d = w_a_neg ^ w_b_neg;
            if (i_op[1]) begin
              acc_d  = {32'd0, w_a_mag};
              opnd_d = w_b_mag;
            end else begin
              acc_d  = {32'd0, w_b_mag};
              opnd_d = w_a_mag;
            end
          end else if (i_op == OP_MTHI) begin
            hi_d = i_a;
          end else if (i_op == OP_MTLO) begin
            lo_d = i_a;
          end
        end
      end

      ST_CALC: begin
        acc_d = is_div_q ? w_div_next : w_mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
          hi_d = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        end else begin
          lo_d = w_prod_fix[31:0];
          hi_d = w_prod_fix[63:32];
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset discards any in-flight operation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Status and read-data outputs
  always_comb begin
    o_busy  = (state_q != ST_IDLE);
    o_stall = i_en & o_busy;
    o_hi    = hi_q;
    o_lo    = lo_q;
    if (i_op == OP_MFHI) begin
      o_result = hi_q;
    end else if (i_op == OP_MFLO) begin
      o_result = lo_q;
    end else begin
      o_result = 32'd0;
    end
  end

endmodule
`default_nettype wire
